bus_port_fifo: RTL and testbench
================================

// Module: bus_port_fifo
// PURPOSE
//  Per-driver endpoint between a client device and the bus driver/arbiter (bs_gnrtr_n_rbtr).
//  TX side buffers client packets and presents them to the bus via pndng/D_pop/pop.
//  RX side captures bus deliveries (push/D_push), filters on destination ID and queues them
//  for the client. One instance per bus driver slot (DRVS instances in the top level).
// PARAMETERS
//  PCKG_SZ  16    packet width in bits; bits [PCKG_SZ-1 -: 8] hold the destination ID
//  DEPTH    16    entries per FIFO (TX and RX); power of 2, >= 2
//  PORT_ID  0     this endpoint's 8-bit ID; RX accepts dest == PORT_ID or dest == 8'hFF
// PORTS
//  clk             in   1        clock, all logic on rising edge
//  reset           in   1        synchronous, active-low reset
//  tx_valid        in   1        client offers tx_data
//  tx_ready        out  1        TX FIFO can accept a word
//  tx_data         in   PCKG_SZ  client packet
//  pndng           out  1        TX FIFO non-empty (to bus)
//  D_pop           out  PCKG_SZ  TX FIFO head (to bus)
//  pop             in   1        bus consumes head
//  push            in   1        bus delivers D_push
//  D_push          in   PCKG_SZ  packet from bus
//  rx_valid        out  1        RX FIFO non-empty
//  rx_ready        in   1        client consumes rx_data
//  rx_data         out  PCKG_SZ  RX FIFO head
//  rx_drop_cnt     out  8        saturating count of packets dropped (RX full)
//  rx_misroute_cnt out  8        saturating count of packets with foreign dest ID
// BEHAVIOUR
//  Reset (reset==0 at posedge): all pointers/counts/counters to 0; while reset==0:
//   tx_ready=0, pndng=0, rx_valid=0, D_pop=0, rx_data=0. tx_ready=1 first cycle after release.
//  Both FIFOs first-word-fall-through; head muxed to 0 when empty (D_pop, rx_data).
//  TX write: tx_valid && tx_ready; tx_ready = !tx_full (registered-count based).
//  TX read: pop && pndng; pop while !pndng ignored, no state change.
//  Latency: word written in cycle N appears on D_pop/pndng in cycle N+1.
//  Simultaneous TX write+pop: full -> pop only (tx_ready=0); empty -> write only, pop ignored;
//   otherwise both, count unchanged.
//  RX accept: push && dest ok -> enqueue if !rx_full; if rx_full -> drop, rx_drop_cnt++ (sat 255).
//   Full check uses current count: push+rx_ready on a full FIFO still drops.
//  RX misroute: push && dest not PORT_ID/8'hFF -> discard, rx_misroute_cnt++ (sat 255).
//  RX read: rx_valid && rx_ready; same FIFO rules and N+1 latency as TX.
//  Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1; full = count==DEPTH.
//  Reset mid-operation: contents discarded, in-flight handshakes in that cycle are lost.
//  No X propagation: D_push sampled only when push==1.
// STRUCTURE
//  bus_port_pkg: ID_W=8, BCAST_ID=8'hFF, function dest_of(pkt) returning top ID_W bits.
//  Sub-module sync_fifo #(W, DEPTH): FWFT, wr_en/rd_en/full/empty/count/head; instantiated
//   once for TX, once for RX. Filter, counters and reset gating in bus_port_fifo.
// TESTING
//  1 reset low 3 cycles with tx_valid=1 -> tx_ready=0, pndng=0, counters 0; release -> ready=1.
//  2 write 0x0301,0x0302 then pop each cycle -> D_pop 0x0301 then 0x0302, pndng falls after 2nd.
//  3 fill TX with 16 words, tx_valid held -> tx_ready=0 on cycle 17, pop+valid -> one slot freed.
//  4 PORT_ID=3: push 0x03AA, 0xFF55, 0x0477 -> rx_data 0x03AA, 0xFF55; rx_misroute_cnt=1.
//  5 RX full (16) + push 0x0300 with rx_ready=1 -> dropped, rx_drop_cnt=1, 16 valid reads.
//  6 pop on empty and reset asserted mid-burst (8 queued) -> no change / FIFOs empty next cycle.

Source files
------------

// File: rtl/bus_port_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bus_port_pkg
//  Description : Shared constants and the destination-ID helper for the bus
//                endpoint FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_port_pkg;

    localparam int             ID_W      = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
    // Widest packet the helper below can decode.
    localparam int             PKT_MAX_W = 64;

    // Destination ID lives in the top ID_W bits of a pkt_w-bit packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned           pkt_w);
        return ID_W'(pkt >> (pkt_w - ID_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_port_fifo_if.sv
`default_nettype none
// ============================================================================
//  Interface   : bus_port_fifo_if
//  Description : Client TX/RX handshakes and bus pop/push signals of one
//                endpoint. slave = the endpoint, master = client + bus side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_port_fifo_if #(
    parameter int PCKG_SZ = 16
) ();
    logic               tx_valid;
    logic               tx_ready;
    logic [PCKG_SZ-1:0] tx_data;
    logic               pndng;
    logic [PCKG_SZ-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [PCKG_SZ-1:0] D_push;
    logic               rx_valid;
    logic               rx_ready;
    logic [PCKG_SZ-1:0] rx_data;
    logic [7:0]         rx_drop_cnt;
    logic [7:0]         rx_misroute_cnt;

    modport slave (
        input  tx_valid, tx_data, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_valid, rx_data, rx_drop_cnt, rx_misroute_cnt
    );

    modport master (
        output tx_valid, tx_data, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_valid, rx_data, rx_drop_cnt, rx_misroute_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bus_port_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : First-word-fall-through synchronous FIFO. Head reads as 0
//                while empty; writes when full and reads when empty are
//                ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       wr_en,
    input  wire logic [W-1:0]               wr_data,
    input  wire logic                       rd_en,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          count,
    output logic [W-1:0]                    head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = empty ? '0 : r_mem[r_rd_ptr];
    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end
endmodule
`default_nettype wire

// File: rtl/bus_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bus_port_fifo
//  Description : Bus driver endpoint. TX FIFO feeds the bus (pndng/D_pop/pop),
//                RX FIFO captures bus deliveries filtered on destination ID,
//                with saturating drop and misroute counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_port_fifo
    import bus_port_pkg::*;
#(
    parameter int              PCKG_SZ = 16,
    parameter int              DEPTH   = 16,
    parameter logic [ID_W-1:0] PORT_ID = 8'd0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    bus_port_fifo_if.slave     bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [CW-1:0]      w_tx_count, w_rx_count;
    logic [PCKG_SZ-1:0] w_tx_head, w_rx_head;
    logic [PCKG_SZ-1:0] w_push_pkt;
    logic [ID_W-1:0]    w_dest;
    logic               w_dest_ok;
    logic               w_tx_wr, w_tx_rd, w_rx_wr, w_rx_rd;
    logic               w_rx_drop, w_rx_mis;
    logic [7:0]         r_drop_cnt, r_mis_cnt;
    logic               w_unused;

    // Bus data is only looked at while push is high, so an idle X bus stays contained.
    assign w_push_pkt = bus.push ? bus.D_push : '0;
    assign w_dest     = dest_of(PKT_MAX_W'(w_push_pkt), PCKG_SZ);
    assign w_dest_ok  = (w_dest == PORT_ID) || (w_dest == BCAST_ID);

    // Every handshake is gated by reset so in-flight transfers are lost.
    assign w_tx_wr   = reset && bus.tx_valid && !w_tx_full;
    assign w_tx_rd   = reset && bus.pop && !w_tx_empty;
    assign w_rx_wr   = reset && bus.push && w_dest_ok && !w_rx_full;
    assign w_rx_drop = reset && bus.push && w_dest_ok && w_rx_full;
    assign w_rx_mis  = reset && bus.push && !w_dest_ok;
    assign w_rx_rd   = reset && bus.rx_ready && !w_rx_empty;

    assign bus.tx_ready        = reset && !w_tx_full;
    assign bus.pndng           = reset && !w_tx_empty;
    assign bus.D_pop           = reset ? w_tx_head : '0;
    assign bus.rx_valid        = reset && !w_rx_empty;
    assign bus.rx_data         = reset ? w_rx_head : '0;
    assign bus.rx_drop_cnt     = r_drop_cnt;
    assign bus.rx_misroute_cnt = r_mis_cnt;

    assign w_unused = ^{w_tx_count, w_rx_count};

    sync_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_tx_wr),
        .wr_data (bus.tx_data),
        .rd_en   (w_tx_rd),
        .full    (w_tx_full),
        .empty   (w_tx_empty),
        .count   (w_tx_count),
        .head    (w_tx_head)
    );

    sync_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_rx_wr),
        .wr_data (w_push_pkt),
        .rd_en   (w_rx_rd),
        .full    (w_rx_full),
        .empty   (w_rx_empty),
        .count   (w_rx_count),
        .head    (w_rx_head)
    );

    // Saturating drop / misroute event counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= '0;
            r_mis_cnt  <= '0;
        end else begin
            if (w_rx_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_rx_mis  && (r_mis_cnt  != 8'hFF)) r_mis_cnt  <= r_mis_cnt  + 8'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bus_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_port_fifo
//  Description : Self-checking bench for bus_port_fifo with a queue-based
//                reference model of both FIFOs and the RX filter counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_port_fifo;
    localparam int         DEPTH = 16;
    localparam logic [7:0] PID   = 8'h03;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_port_fifo_if #(.PCKG_SZ(16)) bus ();

    bus_port_fifo #(.PCKG_SZ(16), .DEPTH(DEPTH), .PORT_ID(PID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic [7:0]  m_drop = 8'd0;
    logic [7:0]  m_mis  = 8'd0;
    logic        rst_n  = 1'b0;

    function automatic logic [50:0] exp_vec();
        logic        tr, pn, rv;
        logic [15:0] dp, rd;
        tr = rst_n && (txq.size() < DEPTH);
        pn = rst_n && (txq.size() > 0);
        dp = pn ? txq[0] : 16'h0;
        rv = rst_n && (rxq.size() > 0);
        rd = rv ? rxq[0] : 16'h0;
        return {tr, pn, dp, rv, rd, m_drop, m_mis};
    endfunction

    function automatic logic [50:0] obs_vec();
        return {bus.tx_ready, bus.pndng, bus.D_pop, bus.rx_valid, bus.rx_data,
                bus.rx_drop_cnt, bus.rx_misroute_cnt};
    endfunction

    // Drive one cycle of inputs, clock it, and advance the model by the same rules.
    task automatic step(input logic r, input logic tv, input logic [15:0] td, input logic pp,
                        input logic ps, input logic [15:0] dp, input logic rr);
        logic tw, trd, rw, rrd, dr, mr, ok;
        reset = r; rst_n = r;
        bus.tx_valid = tv; bus.tx_data = td; bus.pop = pp;
        bus.push = ps; bus.D_push = dp; bus.rx_ready = rr;
        ok  = (dp[15:8] == PID) || (dp[15:8] == 8'hFF);
        tw  = r && tv && (txq.size() < DEPTH);
        trd = r && pp && (txq.size() > 0);
        rw  = r && ps && ok && (rxq.size() < DEPTH);
        dr  = r && ps && ok && (rxq.size() == DEPTH);
        mr  = r && ps && !ok;
        rrd = r && rr && (rxq.size() > 0);
        @(posedge clk);
        #1;
        if (!r) begin
            txq.delete(); rxq.delete(); m_drop = 8'd0; m_mis = 8'd0;
        end else begin
            if (trd) void'(txq.pop_front());
            if (tw)  txq.push_back(td);
            if (rrd) void'(rxq.pop_front());
            if (rw)  rxq.push_back(dp);
            if (dr && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            if (mr && m_mis  != 8'hFF) m_mis  = m_mis  + 8'd1;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b0);
            n_vec++;
            if ({bus.tx_ready, bus.pndng, bus.rx_valid, bus.rx_drop_cnt, bus.rx_misroute_cnt} !== 19'h0) begin
                n_err++;
                $display("FAIL reset_hold got rdy=%b pnd=%b rxv=%b drop=%0d mis=%0d expected all 0",
                         bus.tx_ready, bus.pndng, bus.rx_valid, bus.rx_drop_cnt, bus.rx_misroute_cnt);
            end
        end
        idle();
        n_vec++;
        if (bus.tx_ready !== 1'b1 || bus.pndng !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got rdy=%b pnd=%b expected rdy=1 pnd=0", bus.tx_ready, bus.pndng);
        end
    endtask

    task automatic test_tx_order();
        logic [15:0] exp_w [2];
        exp_w[0] = 16'h0301; exp_w[1] = 16'h0302;
        step(1'b1, 1'b1, 16'h0301, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h0302, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (bus.pndng !== 1'b1 || bus.D_pop !== exp_w[i]) begin
                n_err++;
                $display("FAIL tx_order[%0d] got pnd=%b D_pop=%h expected pnd=1 D_pop=%h",
                         i, bus.pndng, bus.D_pop, exp_w[i]);
            end
            step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        end
        n_vec++;
        if (bus.pndng !== 1'b0 || bus.D_pop !== 16'h0) begin
            n_err++;
            $display("FAIL tx_drained got pnd=%b D_pop=%h expected pnd=0 D_pop=0000", bus.pndng, bus.D_pop);
        end
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 16'h0500 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
        n_vec++;
        if (bus.tx_ready !== 1'b0 || bus.D_pop !== 16'h0500) begin
            n_err++;
            $display("FAIL tx_full got rdy=%b D_pop=%h expected rdy=0 D_pop=0500", bus.tx_ready, bus.D_pop);
        end
        // Write offered while full together with a pop: only the pop happens.
        step(1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0, 1'b0);
        n_vec++;
        if (bus.tx_ready !== 1'b1 || bus.D_pop !== 16'h0501) begin
            n_err++;
            $display("FAIL tx_full_pop got rdy=%b D_pop=%h expected rdy=1 D_pop=0501", bus.tx_ready, bus.D_pop);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL tx_drain[%0d] got %h expected %h", i, obs_vec(), exp_vec());
            end
            step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        end
        n_vec++;
        if (bus.pndng !== 1'b0) begin
            n_err++;
            $display("FAIL tx_full_drained got pnd=%b expected 0", bus.pndng);
        end
    endtask

    task automatic test_rx_filter();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h03AA, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFF55, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0477, 1'b0);
        n_vec++;
        if (bus.rx_data !== 16'h03AA || bus.rx_misroute_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rx_filter_0 got rx_data=%h mis=%0d expected 03aa mis=1", bus.rx_data, bus.rx_misroute_cnt);
        end
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if (bus.rx_data !== 16'hFF55 || bus.rx_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rx_filter_1 got rx_data=%h rxv=%b expected ff55 rxv=1", bus.rx_data, bus.rx_valid);
        end
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if (bus.rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rx_filter_empty got rxv=%b expected 0", bus.rx_valid);
        end
    endtask

    task automatic test_rx_full_drop();
        int reads;
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, {PID, 8'($urandom)}, 1'b0);
        // Full FIFO: the read proceeds but the simultaneous push is still dropped.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0300, 1'b1);
        n_vec++;
        if (bus.rx_drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL rx_drop_cnt got %0d expected 1", bus.rx_drop_cnt);
        end
        reads = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rx_valid) reads++;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rx_drain[%0d] got %h expected %h", i, obs_vec(), exp_vec());
            end
            step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        end
        n_vec++;
        if (reads !== DEPTH || bus.rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rx_read_count got %0d rxv=%b expected %0d rxv=0", reads, bus.rx_valid, DEPTH);
        end
    endtask

    task automatic test_pop_empty_and_reset();
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec() || bus.pndng !== 1'b0 || bus.tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pop_empty got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 16'h0700 + 16'(i), 1'b0, 1'b1, {8'hFF, 8'(i)}, 1'b0);
        step(1'b0, 1'b1, 16'h0BAD, 1'b1, 1'b1, 16'h03BB, 1'b1);
        n_vec++;
        if (bus.pndng !== 1'b0 || bus.rx_valid !== 1'b0 || bus.D_pop !== 16'h0 || bus.rx_data !== 16'h0) begin
            n_err++;
            $display("FAIL mid_reset got pnd=%b rxv=%b D_pop=%h rx_data=%h expected all 0",
                     bus.pndng, bus.rx_valid, bus.D_pop, bus.rx_data);
        end
        idle();
        n_vec++;
        if (obs_vec() !== exp_vec() || bus.tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic        r, tv, pp, ps, rr;
        logic [7:0]  d;
        for (int c = 0; c < 800; c++) begin
            r  = ($urandom_range(0, 149) != 0);
            tv = ($urandom_range(0, 99) < 70);
            pp = ($urandom_range(0, 99) < ((c % 200) < 100 ? 20 : 80));
            ps = ($urandom_range(0, 99) < 65);
            rr = ($urandom_range(0, 99) < ((c % 200) < 100 ? 15 : 80));
            case ($urandom_range(0, 2))
                0:       d = PID;
                1:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            step(r, tv, 16'($urandom), pp, ps, {d, 8'($urandom)}, rr);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d] got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = '0; bus.pop = 1'b0;
        bus.push = 1'b0; bus.D_push = '0; bus.rx_ready = 1'b0;
        test_reset();
        test_tx_order();
        test_tx_full();
        test_rx_filter();
        test_rx_full_drop();
        test_pop_empty_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
